// File: rtl/nrisc_mem_pkg.sv
// nrisc_mem_pkg: shared types and default widths for the unified memory controller.
// Provides port FSM states, grant encoding and the stall counter width helper.
package nrisc_mem_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_MAX_STALL = 3;

    typedef enum logic {
        P_IDLE,
        P_ACK
    } port_state_e;

    typedef enum logic [1:0] {
        G_NONE,
        G_I,
        G_D
    } grant_e;

    function automatic int stall_w(input int max_stall);
        return (max_stall < 1) ? 1 : $clog2(max_stall + 1);
    endfunction

endpackage

// File: rtl/sp_ram.sv
// sp_ram: single-port synchronous RAM, read-before-write, no reset on contents.
// Ports: clk, en, we, addr[ADDR_W], wdata[DATA_W] in; rdata[DATA_W] out (registered).
module sp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: one single-port RAM shared by a fetch port and a data port.
// Ports: clk, reset (async, active-low); fetch i_req/i_addr -> i_rdata/i_ack;
//   data d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack; conflict flag.
// Build option MEMCTRL_PERF_EN adds perf_conflicts/perf_forced (32b saturating).
module unified_mem_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MAX_STALL = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
`ifdef MEMCTRL_PERF_EN
    output logic              conflict,
    output logic [31:0]       perf_conflicts,
    output logic [31:0]       perf_forced
`else
    output logic              conflict
`endif
);

    import nrisc_mem_pkg::*;

    localparam int SW = stall_w(MAX_STALL);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    port_state_e i_st, i_st_n;
    port_state_e d_st, d_st_n;
    logic [SW-1:0] stall_q, stall_n;
    logic conf_q, conf_n;

    logic i_elig, d_elig, both, forced;
    grant_e gnt;

    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_st    <= P_IDLE;
            d_st    <= P_IDLE;
            stall_q <= '0;
            conf_q  <= 1'b0;
        end else begin
            i_st    <= i_st_n;
            d_st    <= d_st_n;
            stall_q <= stall_n;
            conf_q  <= conf_n;
        end
    end

    always_comb begin
        i_elig  = i_req && (i_st == P_IDLE);
        d_elig  = d_req && (d_st == P_IDLE);
        both    = i_elig && d_elig;
        forced  = both && (stall_q == STALL_MAX);
        gnt     = G_NONE;
        stall_n = stall_q;
        conf_n  = both;

        unique case (1'b1)
            forced:                gnt = G_I;
            (d_elig && !forced):   gnt = G_D;
            (i_elig && !d_elig):   gnt = G_I;
            default:               gnt = G_NONE;
        endcase

        // ACK always lasts one cycle; only an idle port can be granted
        i_st_n = (gnt == G_I) ? P_ACK : P_IDLE;
        d_st_n = (gnt == G_D) ? P_ACK : P_IDLE;

        if (gnt == G_I) begin
            stall_n = '0;
        end else if (both && (stall_q < STALL_MAX)) begin
            stall_n = stall_q + 1'b1;
        end
    end

    // Reset gates the RAM so nothing is written while reset is held
    assign ram_en   = (gnt != G_NONE) && reset;
    assign ram_we   = (gnt == G_D) && d_we;
    assign ram_addr = (gnt == G_D) ? d_addr : i_addr;

    sp_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(d_wdata),
        .rdata(ram_q)
    );

    // One grant per edge, so the shared read register belongs to the acking port
    assign i_ack    = (i_st == P_ACK);
    assign d_ack    = (d_st == P_ACK);
    assign i_rdata  = i_ack ? ram_q : '0;
    assign d_rdata  = d_ack ? ram_q : '0;
    assign conflict = conf_q;

`ifdef MEMCTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_conflicts <= '0;
            perf_forced    <= '0;
        end else begin
            if (both && (perf_conflicts != '1)) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
            if (forced && (perf_forced != '1)) begin
                perf_forced <= perf_forced + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb_unified_mem_ctrl: scoreboard bench for unified_mem_ctrl with a rule-level model.
// Directed scenarios followed by randomized two-port traffic.
module tb_unified_mem_ctrl;

    localparam int MS = 3;

    logic       clk;
    logic       reset;
    logic       i_req;
    logic [7:0] i_addr;
    logic [7:0] i_rdata;
    logic       i_ack;
    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic [7:0] d_rdata;
    logic       d_ack;
    logic       conflict;
`ifdef MEMCTRL_PERF_EN
    logic [31:0] perf_conflicts;
    logic [31:0] perf_forced;
`endif

    unified_mem_ctrl #(
        .DATA_W(8),
        .ADDR_W(8),
        .MAX_STALL(MS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
`ifdef MEMCTRL_PERF_EN
        .conflict      (conflict),
        .perf_conflicts(perf_conflicts),
        .perf_forced   (perf_forced)
`else
        .conflict(conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        bit       is_i;
        logic [7:0] data;
        bit       conf;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a port is eligible unless it was granted on the
    // previous edge; data beats fetch on a tie unless fetch has already
    // lost MS ties in a row since its last grant.
    logic [7:0] mmem [256];
    int  cyc = 0;
    int  i_last = -10;
    int  d_last = -10;
    int  losses = 0;
    int  m_conf = 0;
    int  m_forced = 0;
    bit  ie, de, tie;
    int  win;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            i_last = -10;
            d_last = -10;
            losses = 0;
            m_conf = 0;
            m_forced = 0;
        end else begin
            ie  = i_req && (i_last != cyc - 1);
            de  = d_req && (d_last != cyc - 1);
            tie = ie && de;
            win = 0;
            if (tie) begin
                m_conf++;
                if (losses == MS) begin
                    win = 1;
                    m_forced++;
                end else begin
                    win = 2;
                    losses++;
                end
            end else if (ie) begin
                win = 1;
            end else if (de) begin
                win = 2;
            end
            if (win == 1) begin
                losses = 0;
                i_last = cyc;
                sb.push_back('{cyc, 1'b1, mmem[i_addr], tie});
            end else if (win == 2) begin
                d_last = cyc;
                sb.push_back('{cyc, 1'b0, mmem[d_addr], tie});
                if (d_we) mmem[d_addr] = d_wdata;
            end
        end
    end

    // Monitor: pops the scoreboard whenever an ack is presented
    exp_t e;
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_outs", {i_ack, d_ack, conflict, i_rdata, d_rdata}, '0);
        end else if (i_ack || d_ack) begin
            chk("one_ack", {31'd0, i_ack && d_ack}, 0);
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL spurious_ack: got i_ack=%0b d_ack=%0b expected none",
                         i_ack, d_ack);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {31'd0, i_ack}, {31'd0, e.is_i});
                chk("ack_conf", {31'd0, conflict}, {31'd0, e.conf});
                if (^e.data !== 1'bx) begin
                    chk("ack_data", e.is_i ? i_rdata : d_rdata, e.data);
                end
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_ack: got no ack expected %s ack",
                     sb[0].is_i ? "fetch" : "data");
            void'(sb.pop_front());
        end
    end

    task automatic do_d(input logic we, input logic [7:0] a,
                        input logic [7:0] wd, output logic [7:0] rd);
        bit got;
        got = 0;
        rd = '0;
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (d_ack) begin
                rd = d_rdata;
                got = 1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL d_timeout: got no d_ack expected one within 20 cycles");
        end
        d_req = 1'b0;
    endtask

    task automatic do_i(input logic [7:0] a, output logic [7:0] rd);
        bit got;
        got = 0;
        rd = '0;
        i_req = 1'b1;
        i_addr = a;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (i_ack) begin
                rd = i_rdata;
                got = 1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL i_timeout: got no i_ack expected one within 20 cycles");
        end
        i_req = 1'b0;
    endtask

    logic [7:0] r;

    initial begin
        reset = 1'b0;
        i_req = 1'b0;
        i_addr = '0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int a = 0; a < 256; a++) begin
            do_d(1'b1, 8'(a), 8'(a) ^ 8'h5A, r);
        end

        do_d(1'b1, 8'h10, 8'hA5, r);
        do_i(8'h10, r);
        chk("fetch_a5", r, 8'hA5);

        do_d(1'b1, 8'h20, 8'h3C, r);
        chk("wr_old", r, 8'h7A);
        do_d(1'b0, 8'h20, 8'h00, r);
        chk("rd_back", r, 8'h3C);

        // Both ports held: strict D,I,D,I with a conflict only on the first edge
        repeat (2) @(negedge clk);
        i_req = 1'b1;
        d_req = 1'b1;
        d_we = 1'b1;
        i_addr = 8'h30;
        d_addr = 8'h30;
        d_wdata = 8'($urandom);
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk("alt_d", {31'd0, d_ack}, (j % 2 == 0) ? 1 : 0);
            chk("alt_i", {31'd0, i_ack}, (j % 2 == 1) ? 1 : 0);
            chk("alt_conf", {31'd0, conflict}, (j == 0) ? 1 : 0);
            d_wdata = 8'($urandom);
        end
        i_req = 1'b0;
        d_req = 1'b0;

        // Reset asserted right after a write grant edge
        @(posedge clk);
        #1;
        i_req = 1'b1;
        i_addr = 8'h41;
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 8'h40;
        d_wdata = 8'h77;
        @(posedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("rst_now", {i_ack, d_ack, conflict, i_rdata, d_rdata}, '0);
        d_wdata = 8'h99;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_req = 1'b0;
        d_req = 1'b0;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst", {30'd0, i_ack, d_ack}, 0);
        end
        do_d(1'b0, 8'h40, 8'h00, r);
        chk("rst_commit", r, 8'h77);

        // Ties every other cycle: fetch forced on the 4th conflict
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 9; j++) begin
            i_req = (j % 2 == 0);
            d_req = (j % 2 == 0);
            d_we = 1'b0;
            i_addr = 8'($urandom);
            d_addr = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("frc_d", {31'd0, d_ack}, (j % 2 == 0 && j != 6) ? 1 : 0);
            chk("frc_i", {31'd0, i_ack}, (j == 6) ? 1 : 0);
            chk("frc_conf", {31'd0, conflict}, (j % 2 == 0) ? 1 : 0);
        end
        i_req = 1'b0;
        d_req = 1'b0;

        repeat (1500) begin
            @(posedge clk);
            #1;
            i_req = ($urandom % 4) != 0;
            d_req = ($urandom % 4) != 0;
            d_we = 1'($urandom);
            i_addr = 8'($urandom % 64);
            d_addr = 8'($urandom % 64);
            d_wdata = 8'($urandom);
        end
        @(posedge clk);
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (4) @(negedge clk);

`ifdef MEMCTRL_PERF_EN
        chk("perf_conflicts", perf_conflicts, 32'(m_conf));
        chk("perf_forced", perf_forced, 32'(m_forced));
`endif
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
